operand_queue: RTL
==================

Name: operand_queue

Overview:
- Circular operand queue directly downstream of the calculator ALU.
- Executes the ALU's queue_op (push / sleep / pop / get-and-push) using the ALU result as the push value.
- Presents the two oldest entries back to the ALU as its 16-bit operands bus.
- Flags queue overflow/underflow and ALU-reported calculation errors in a sticky error state.

Parameters:
- DEPTH, 16: number of 8-bit entries; power of two, >= 2.
- Q_PUSH, 2'b00: push push_val at tail.
- Q_SLEEP, 2'b01: no operation.
- Q_POP, 2'b11: remove head entry.
- Q_GET_AND_PUSH, 2'b10: remove two head entries, push push_val.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op_valid  in  1  queue_op/push_val/calc_err valid this cycle.
- op_ready  out  1  queue accepts an op; op executes on the edge where op_valid && op_ready.
- queue_op  in  2  operation from ALU.
- push_val  in  8  ALU result.
- calc_err  in  1  ALU calc error (divide/remainder by zero) for this op.
- err_clr  in  1  one-cycle pulse; leaves ERROR state.
- operands  out  16  [7:0] = head entry, [15:8] = head+1 entry.
- operands_valid  out  1  count >= 2.
- pop_data  out  8  value removed by last Q_POP.
- pop_valid  out  1  one-cycle pulse with pop_data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  1  high in ERROR state.
- err_code  out  2  00 none, 01 overflow, 10 underflow, 11 calc error.

Behaviour:
- Reset (async, any time, mid-operation included):
  - head = tail = count = 0; state = RUN.
  - pop_data = 0, pop_valid = 0, err = 0, err_code = 00.
  - Memory contents are don't-care.
- State machine with two states, RUN and ERROR; op_ready = (state == RUN).
- RUN, accepted op, evaluated in priority order:
  - calc_err = 1: error 11; no queue change.
  - Q_PUSH, full: error 01.
  - Q_PUSH, not full: mem[tail] = push_val; tail += 1; count += 1.
  - Q_POP, empty: error 10.
  - Q_POP, not empty: pop_data = mem[head], pop_valid = 1 for the next cycle; head += 1; count -= 1.
  - Q_GET_AND_PUSH, count < 2: error 10.
  - Q_GET_AND_PUSH, count >= 2: head += 2; mem[tail] = push_val; tail += 1; count -= 1. The write uses the pre-update tail. Not an overflow even when full, since the net change is -1.
  - Q_SLEEP: nothing.
- Any error: queue state is unchanged, err_code is latched, and the block moves to ERROR on that edge.
- ERROR state:
  - op_ready = 0; ops are ignored and queue contents are preserved.
  - err_clr = 1 → RUN and err_code = 00 on the next edge.
  - err_clr in RUN has no effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. head+1 for operands[15:8] also wraps.
- Outputs:
  - operands, full, empty, count and operands_valid are combinational from registered state, so the new value is visible the cycle after the accepting edge (1-cycle latency).
  - Entries at or beyond count read as 0: empty → operands = 0; count == 1 → operands[15:8] = 0.
  - pop_valid is low in every cycle except the one following a successful pop.
- Arithmetic: none. Values are stored unmodified, 8 bits.

Test Plan:
- Reset → count = 0, empty = 1, op_ready = 1, operands = 16'h0000. Assert rst asynchronously mid-stream after 3 pushes → count = 0 immediately, before the next clock edge.
- Push 8'h05, then 8'h03, then GET_AND_PUSH with push_val = 8'h08:
  - after the pushes: operands = 16'h0305;
  - after GET_AND_PUSH: count = 1, operands = 16'h0008, operands_valid = 0.
- Fill DEPTH = 16 entries, then push again → err = 1, err_code = 01, count stays 16, op_ready = 0. Then GET_AND_PUSH in ERROR is ignored. Then err_clr → RUN, op_ready = 1.
- Queue empty, POP → err_code = 10. Queue holding one entry, GET_AND_PUSH → err_code = 10, count stays 1.
- Push 8'hAA, POP → pop_valid high exactly one cycle with pop_data = 8'hAA, empty = 1. op_valid with calc_err = 1 and Q_GET_AND_PUSH → err_code = 11, queue unchanged.
- Wrap-around: 14 pushes, 14 pops, then push 8'h11 and 8'h22 (occupying slots 14 and 15), then push 8'h33 → tail wraps to slot 0, and operands = 16'h2211 with the head at slot 14. Then GET_AND_PUSH with push_val = 8'h33 → operands = 16'h3333, count = 2.

Source files
------------

// File: rtl/operand_queue.sv
// Circular 8-bit operand queue fed by the calculator ALU.
// Presents the two oldest entries as the ALU operand bus; sticky error state.
module operand_queue #(
  parameter int         DEPTH          = 16,
  parameter logic [1:0] Q_PUSH         = 2'b00,
  parameter logic [1:0] Q_SLEEP        = 2'b01,
  parameter logic [1:0] Q_POP          = 2'b11,
  parameter logic [1:0] Q_GET_AND_PUSH = 2'b10,
  localparam int        PW             = $clog2(DEPTH),
  localparam int        CW             = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    queue_op,
  input  logic [7:0]    push_val,
  input  logic          calc_err,
  input  logic          err_clr,
  output logic [15:0]   operands,
  output logic          operands_valid,
  output logic [7:0]    pop_data,
  output logic          pop_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic S_RUN   = 1'b0;
  localparam logic S_ERROR = 1'b1;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_OVF  = 2'b01;
  localparam logic [1:0] E_UDF  = 2'b10;
  localparam logic [1:0] E_CALC = 2'b11;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          state_q, state_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    pop_data_q, pop_data_d;
  logic          pop_valid_q, pop_valid_d;
  logic          we;
  logic [1:0]    code;
  logic [PW-1:0] head_nx;

  assign head_nx        = head_q + PW'(1);
  assign count          = count_q;
  assign full           = (count_q == FULL_CNT);
  assign empty          = (count_q == '0);
  assign operands_valid = (count_q >= CW'(2));
  assign op_ready       = (state_q == S_RUN);
  assign err            = (state_q == S_ERROR);
  assign err_code       = err_code_q;
  assign pop_data       = pop_data_q;
  assign pop_valid      = pop_valid_q;

  // Slots at or beyond the occupancy hold stale data and read as zero.
  assign operands[7:0]  = empty ? 8'h00 : mem_q[head_q];
  assign operands[15:8] = operands_valid ? mem_q[head_nx] : 8'h00;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    err_code_d  = err_code_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    we          = 1'b0;
    code        = E_NONE;
    case (state_q)
      S_RUN: begin
        if (op_valid) begin
          if (calc_err) begin
            code = E_CALC;
          end else begin
            case (queue_op)
              Q_PUSH: begin
                if (full) begin
                  code = E_OVF;
                end else begin
                  we      = 1'b1;
                  tail_d  = tail_q + PW'(1);
                  count_d = count_q + CW'(1);
                end
              end
              Q_POP: begin
                if (empty) begin
                  code = E_UDF;
                end else begin
                  pop_data_d  = mem_q[head_q];
                  pop_valid_d = 1'b1;
                  head_d      = head_nx;
                  count_d     = count_q - CW'(1);
                end
              end
              // Net occupancy change is -1, so a full queue cannot overflow.
              Q_GET_AND_PUSH: begin
                if (!operands_valid) begin
                  code = E_UDF;
                end else begin
                  we      = 1'b1;
                  head_d  = head_q + PW'(2);
                  tail_d  = tail_q + PW'(1);
                  count_d = count_q - CW'(1);
                end
              end
              default: ;
            endcase
          end
          if (code != E_NONE) begin
            state_d    = S_ERROR;
            err_code_d = code;
          end
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          state_d    = S_RUN;
          err_code_d = E_NONE;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= S_RUN;
      err_code_q  <= E_NONE;
      pop_data_q  <= 8'h00;
      pop_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[tail_q] <= push_val;
  end

endmodule
